dmem_port_arbiter: RTL and testbench

- Single-port arbiter and byte-lane controller in front of the data memory BRAM.
- Shares the memory between two requesters:
  - the core MEM stage, which has priority;
  - a debug/program-loader port with valid/grant handshake.
- Generates byte enables and lane-replicated write data from funct3 and the low address bits, flags misaligned core accesses, and routes the 1-cycle-latency read data back to the requester that issued the read.
- Sits between the MEM stage and the data memory array.

---
 rtl/dmem_port_arbiter_pkg.sv | 23 ++
 rtl/dmem_port_arbiter_if.sv | 53 +++++
 rtl/dmem_port_arbiter_lane_gen.sv | 54 +++++
 rtl/dmem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: widths, RV32 load/store
// funct3 codes, arbiter state and read-response owner encodings.
// Latency: n/a (types and constants only). Backpressure: n/a.
package dmem_port_arbiter_pkg;

  localparam int DATA_WIDTH           = 32;
  localparam int DATA_MEM_ADDR_WIDTH  = 10;
  localparam int STARVE_LIMIT_DEFAULT = 8;

  // RV32 load/store funct3 encodings (loads and stores share the code space)
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {S_CORE, S_FORCE, S_LOCK} arb_state_e;
  typedef enum logic [1:0] {NONE, CORE, DBG} rsp_owner_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of core, debug and memory-side signals around the data-memory arbiter.
// Latency: n/a (wiring only). Backpressure: core/debug stall via their gnt signals.
// Modports: slave = arbiter side, master = requesters + memory side.
interface dmem_port_arbiter_if;
  import dmem_port_arbiter_pkg::*;

  // core MEM stage
  logic                           core_req_i;
  logic                           core_we_i;
  logic [2:0]                     core_funct3_i;
  logic [DATA_WIDTH-1:0]          core_addr_i;
  logic [DATA_WIDTH-1:0]          core_wdata_i;
  logic                           core_gnt_o;
  logic                           core_misalign_o;
  logic                           core_rvalid_o;
  logic [DATA_WIDTH-1:0]          core_rdata_o;
  // debug / program-loader port
  logic                           dbg_req_i;
  logic                           dbg_we_i;
  logic [3:0]                     dbg_be_i;
  logic [DATA_MEM_ADDR_WIDTH-1:0] dbg_addr_i;
  logic [DATA_WIDTH-1:0]          dbg_wdata_i;
  logic                           dbg_lock_i;
  logic                           dbg_gnt_o;
  logic                           dbg_rvalid_o;
  logic [DATA_WIDTH-1:0]          dbg_rdata_o;
  // data memory
  logic                           mem_en_o;
  logic                           mem_we_o;
  logic [3:0]                     mem_be_o;
  logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0]          mem_wdata_o;
  logic [DATA_WIDTH-1:0]          mem_rdata_i;

  modport slave (
    input  core_req_i, core_we_i, core_funct3_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_misalign_o, core_rvalid_o, core_rdata_o,
    input  dbg_req_i, dbg_we_i, dbg_be_i, dbg_addr_i, dbg_wdata_i, dbg_lock_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output core_req_i, core_we_i, core_funct3_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_misalign_o, core_rvalid_o, core_rdata_o,
    output dbg_req_i, dbg_we_i, dbg_be_i, dbg_addr_i, dbg_wdata_i, dbg_lock_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/dmem_port_arbiter_lane_gen.sv
// Byte-lane generator: funct3 + addr[1:0] + store data -> byte enables, lane data, misalign flag.
// Latency: purely combinational. Backpressure: none.
// Ports: we, funct3, addr_lo, wdata_in in; be, wdata, misalign out.
module dmem_lane_gen
  import dmem_port_arbiter_pkg::*;
(
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  misalign
);

  always_comb begin
    be       = 4'b0000;
    wdata    = wdata_in;
    misalign = 1'b0;
    if (we) begin
      case (funct3)
        FUNCT3_SB: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{wdata_in[7:0]}};
        end
        FUNCT3_SH: begin
          be       = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata    = {2{wdata_in[15:0]}};
          misalign = addr_lo[0];
        end
        FUNCT3_SW: begin
          be       = 4'b1111;
          misalign = |addr_lo;
        end
        default: misalign = 1'b1;
      endcase
    end else begin
      // Loads always fetch the whole word; WB picks and extends the lane.
      case (funct3)
        FUNCT3_LB, FUNCT3_LBU: be = 4'b1111;
        FUNCT3_LH, FUNCT3_LHU: begin
          be       = 4'b1111;
          misalign = addr_lo[0];
        end
        FUNCT3_LW: begin
          be       = 4'b1111;
          misalign = |addr_lo;
        end
        default: misalign = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: core MEM stage (priority) vs debug/loader port, with byte-lane control.
// Latency: grants and memory strobes combinational; read data returned 1 cycle after the strobe.
// Backpressure: core stalls on core_gnt_o=0; debug holds dbg_req_i until dbg_gnt_o.
// Ports: clk, rst_n (sync, active-low), bus (slave modport carrying core/dbg/mem signals).
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e state_q, state_d;
  rsp_owner_e owner_q, owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic                  core_gnt, dbg_gnt;
  logic                  core_acc, dbg_acc, dbg_denied;
  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic                  lane_misalign;

  // Byte address bits above the memory window are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.core_addr_i[DATA_WIDTH-1:DATA_MEM_ADDR_WIDTH+2];

  dmem_lane_gen u_lane_gen (
    .we       (bus.core_we_i),
    .funct3   (bus.core_funct3_i),
    .addr_lo  (bus.core_addr_i[1:0]),
    .wdata_in (bus.core_wdata_i),
    .be       (lane_be),
    .wdata    (lane_wdata),
    .misalign (lane_misalign)
  );

  // Grants, next state, starvation counter and response owner.
  always_comb begin
    core_gnt     = 1'b1;
    dbg_gnt      = 1'b0;
    state_d      = state_q;
    starve_cnt_d = '0;
    owner_d      = NONE;

    case (state_q)
      S_FORCE, S_LOCK: begin
        // core_gnt only reads 1 when the core is not asking, so it is stalled.
        core_gnt = ~bus.core_req_i;
        dbg_gnt  = bus.dbg_req_i;
      end
      default: begin
        core_gnt = bus.core_req_i | ~bus.dbg_req_i;
        dbg_gnt  = bus.dbg_req_i & ~bus.core_req_i;
      end
    endcase

    dbg_denied = bus.dbg_req_i & ~dbg_gnt;
    // A misaligned core request is consumed but never reaches the memory.
    core_acc   = bus.core_req_i & core_gnt & ~lane_misalign;
    dbg_acc    = dbg_gnt;

    if (dbg_denied) begin
      starve_cnt_d = (starve_cnt_q == CNT_W'(STARVE_LIMIT)) ? starve_cnt_q
                                                            : starve_cnt_q + CNT_W'(1);
    end

    if (bus.dbg_lock_i) begin
      state_d = S_LOCK;
    end else begin
      case (state_q)
        S_CORE: begin
          if (dbg_denied && starve_cnt_q == CNT_W'(STARVE_LIMIT - 1)) state_d = S_FORCE;
        end
        // S_FORCE grants any pending debug request, so one cycle always suffices.
        default: state_d = S_CORE;
      endcase
    end

    if (core_acc && !bus.core_we_i)   owner_d = CORE;
    else if (dbg_acc && !bus.dbg_we_i) owner_d = DBG;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_CORE;
      starve_cnt_q <= '0;
      owner_q      <= NONE;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
    end
  end

  // Memory side: debug fields pass straight through, core fields via the lane generator.
  always_comb begin
    bus.mem_en_o = core_acc | dbg_acc;
    if (dbg_acc) begin
      bus.mem_we_o    = bus.dbg_we_i;
      bus.mem_be_o    = bus.dbg_be_i;
      bus.mem_addr_o  = bus.dbg_addr_i;
      bus.mem_wdata_o = bus.dbg_wdata_i;
    end else begin
      bus.mem_we_o    = core_acc & bus.core_we_i;
      bus.mem_be_o    = lane_be;
      bus.mem_addr_o  = bus.core_addr_i[DATA_MEM_ADDR_WIDTH+1:2];
      bus.mem_wdata_o = lane_wdata;
    end
  end

  assign bus.core_gnt_o      = core_gnt;
  assign bus.dbg_gnt_o       = dbg_gnt;
  assign bus.core_misalign_o = bus.core_req_i & core_gnt & lane_misalign;

  // Responses are masked while reset is held so an outstanding read is dropped cleanly.
  assign bus.core_rvalid_o = rst_n & (owner_q == CORE);
  assign bus.dbg_rvalid_o  = rst_n & (owner_q == DBG);
  assign bus.core_rdata_o  = bus.core_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.dbg_rdata_o   = bus.dbg_rvalid_o  ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_port_arbiter_if bus ();

  dmem_port_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        is_dbg;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  // Memory contents (read-only model): two tagged words plus an address pattern.
  function automatic logic [31:0] mem_word(input int a);
    if (a == 5) return 32'h0000_0011;
    if (a == 9) return 32'h0000_0022;
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en_o && !bus.mem_we_o) bus.mem_rdata_i <= mem_word(int'(bus.mem_addr_o));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.core_req_i    = 1'b0;
    bus.core_we_i     = 1'b0;
    bus.core_funct3_i = FUNCT3_LW;
    bus.core_addr_i   = '0;
    bus.core_wdata_i  = '0;
    bus.dbg_req_i     = 1'b0;
    bus.dbg_we_i      = 1'b0;
    bus.dbg_be_i      = 4'b0000;
    bus.dbg_addr_i    = '0;
    bus.dbg_wdata_i   = '0;
    bus.dbg_lock_i    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (3) next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (dut.state_q !== S_CORE) $display("FAIL reset_state: got %0d want %0d", dut.state_q, S_CORE); else n_pass++;
    n_checks++; if (dut.starve_cnt_q !== 4'd0) $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt_q); else n_pass++;
    n_checks++; if (bus.core_rvalid_o !== 1'b0) $display("FAIL reset_core_rvalid: got %b want 0", bus.core_rvalid_o); else n_pass++;
    n_checks++; if (bus.dbg_rvalid_o !== 1'b0) $display("FAIL reset_dbg_rvalid: got %b want 0", bus.dbg_rvalid_o); else n_pass++;
    n_checks++; if (bus.core_rdata_o !== 32'h0) $display("FAIL reset_core_rdata: got %h want 0", bus.core_rdata_o); else n_pass++;
    n_checks++; if (bus.dbg_rdata_o !== 32'h0) $display("FAIL reset_dbg_rdata: got %h want 0", bus.dbg_rdata_o); else n_pass++;
    n_checks++; if (bus.core_gnt_o !== 1'b1) $display("FAIL reset_idle_gnt: got %b want 1", bus.core_gnt_o); else n_pass++;
    next_cycle();
  endtask

  task automatic test_store_lanes();
    logic [2:0]  f3   [5] = '{FUNCT3_SB, FUNCT3_SB, FUNCT3_SH, FUNCT3_SH, FUNCT3_SW};
    logic [31:0] addr [5] = '{32'h13, 32'h01, 32'h12, 32'h200, 32'h20};
    logic [31:0] wd   [5] = '{32'hA5, 32'h1234_565A, 32'h9876_BEEF, 32'h0000_1234, 32'h1234_5678};
    logic [3:0]  ebe  [5] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111};
    logic [31:0] ewd  [5] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hBEEF_BEEF, 32'h1234_1234, 32'h1234_5678};
    logic [9:0]  ead  [5] = '{10'd4, 10'd0, 10'd4, 10'd128, 10'd8};
    for (int i = 0; i < 5; i++) begin
      bus.core_req_i    = 1'b1;
      bus.core_we_i     = 1'b1;
      bus.core_funct3_i = f3[i];
      bus.core_addr_i   = addr[i];
      bus.core_wdata_i  = wd[i];
      @(negedge clk);
      n_checks++; if (bus.core_gnt_o !== 1'b1) $display("FAIL store%0d_gnt: got %b want 1", i, bus.core_gnt_o); else n_pass++;
      n_checks++; if ({bus.mem_en_o, bus.mem_we_o} !== 2'b11) $display("FAIL store%0d_en_we: got %b want 11", i, {bus.mem_en_o, bus.mem_we_o}); else n_pass++;
      n_checks++; if (bus.mem_be_o !== ebe[i]) $display("FAIL store%0d_be: got %b want %b", i, bus.mem_be_o, ebe[i]); else n_pass++;
      n_checks++; if (bus.mem_wdata_o !== ewd[i]) $display("FAIL store%0d_wdata: got %h want %h", i, bus.mem_wdata_o, ewd[i]); else n_pass++;
      n_checks++; if (bus.mem_addr_o !== ead[i]) $display("FAIL store%0d_addr: got %0d want %0d", i, bus.mem_addr_o, ead[i]); else n_pass++;
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_misalign();
    logic        we   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3   [6] = '{FUNCT3_LW, FUNCT3_LH, FUNCT3_LHU, FUNCT3_SW, 3'b011, FUNCT3_LBU};
    logic [31:0] addr [6] = '{32'h6, 32'h3, 32'h2A, 32'h42, 32'h40, 32'h2F};
    logic        mis  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rsp_t e;
    for (int i = 0; i < 6; i++) begin
      bus.core_req_i    = 1'b1;
      bus.core_we_i     = we[i];
      bus.core_funct3_i = f3[i];
      bus.core_addr_i   = addr[i];
      bus.core_wdata_i  = 32'hFFFF_FFFF;
      @(negedge clk);
      n_checks++; if (bus.core_misalign_o !== mis[i]) $display("FAIL mis%0d_flag: got %b want %b", i, bus.core_misalign_o, mis[i]); else n_pass++;
      n_checks++; if (bus.mem_en_o !== !mis[i]) $display("FAIL mis%0d_mem_en: got %b want %b", i, bus.mem_en_o, !mis[i]); else n_pass++;
      n_checks++; if (bus.core_gnt_o !== 1'b1) $display("FAIL mis%0d_gnt: got %b want 1", i, bus.core_gnt_o); else n_pass++;
      if (!we[i] && !mis[i]) exp_q.push_back('{1'b0, mem_word(int'(addr[i] >> 2))});
      next_cycle();
      idle();
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++; if (bus.core_rvalid_o !== 1'b1 || bus.core_rdata_o !== e.data) $display("FAIL mis%0d_rsp: got v=%b d=%h want v=1 d=%h", i, bus.core_rvalid_o, bus.core_rdata_o, e.data); else n_pass++;
      end else begin
        n_checks++; if (bus.core_rvalid_o !== 1'b0) $display("FAIL mis%0d_no_rvalid: got %b want 0", i, bus.core_rvalid_o); else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_starve();
    rsp_t e;
    for (int c = 0; c < 10; c++) begin
      bus.core_req_i    = 1'b1;
      bus.core_we_i     = 1'b1;
      bus.core_funct3_i = FUNCT3_SW;
      bus.core_addr_i   = 32'd400;
      bus.core_wdata_i  = 32'h0BAD_0BAD;
      bus.dbg_req_i     = (c <= 8);
      bus.dbg_we_i      = 1'b0;
      bus.dbg_be_i      = 4'b1111;
      bus.dbg_addr_i    = 10'd7;
      @(negedge clk);
      n_checks++; if (bus.core_gnt_o !== (c != 8)) $display("FAIL starve_c%0d_core_gnt: got %b want %b", c, bus.core_gnt_o, (c != 8)); else n_pass++;
      n_checks++; if (bus.dbg_gnt_o !== (c == 8)) $display("FAIL starve_c%0d_dbg_gnt: got %b want %b", c, bus.dbg_gnt_o, (c == 8)); else n_pass++;
      if (c == 7) begin
        n_checks++; if (dut.starve_cnt_q !== 4'd7) $display("FAIL starve_cnt7: got %0d want 7", dut.starve_cnt_q); else n_pass++;
      end
      if (c == 8) exp_q.push_back('{1'b1, mem_word(7)});
      if (c == 9 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++; if (bus.dbg_rvalid_o !== 1'b1 || bus.dbg_rdata_o !== e.data) $display("FAIL starve_dbg_rsp: got v=%b d=%h want v=1 d=%h", bus.dbg_rvalid_o, bus.dbg_rdata_o, e.data); else n_pass++;
        n_checks++; if (bus.core_rvalid_o !== 1'b0) $display("FAIL starve_core_rvalid: got %b want 0", bus.core_rvalid_o); else n_pass++;
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic is_dbg [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   word   [6] = '{5, 9, 21, 22, 23, 24};
    rsp_t e;
    for (int i = 0; i < 7; i++) begin
      idle();
      if (i < 6) begin
        if (is_dbg[i]) begin
          bus.dbg_req_i  = 1'b1;
          bus.dbg_be_i   = 4'b1111;
          bus.dbg_addr_i = 10'(word[i]);
        end else begin
          bus.core_req_i    = 1'b1;
          bus.core_funct3_i = FUNCT3_LW;
          bus.core_addr_i   = 32'(word[i] * 4);
        end
      end
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++; if ({bus.dbg_rvalid_o, bus.core_rvalid_o} !== {e.is_dbg, !e.is_dbg}) $display("FAIL b2b%0d_rvalid: got dbg/core=%b%b want %b%b", i, bus.dbg_rvalid_o, bus.core_rvalid_o, e.is_dbg, !e.is_dbg); else n_pass++;
        n_checks++; if ((e.is_dbg ? bus.dbg_rdata_o : bus.core_rdata_o) !== e.data) $display("FAIL b2b%0d_rdata: got %h want %h", i, (e.is_dbg ? bus.dbg_rdata_o : bus.core_rdata_o), e.data); else n_pass++;
        n_checks++; if ((e.is_dbg ? bus.core_rdata_o : bus.dbg_rdata_o) !== 32'h0) $display("FAIL b2b%0d_other_rdata: got %h want 0", i, (e.is_dbg ? bus.core_rdata_o : bus.dbg_rdata_o)); else n_pass++;
      end
      if (i < 6) begin
        n_checks++; if ((is_dbg[i] ? bus.dbg_gnt_o : bus.core_gnt_o) !== 1'b1) $display("FAIL b2b%0d_gnt: got 0 want 1", i); else n_pass++;
        exp_q.push_back('{is_dbg[i], mem_word(word[i])});
      end
      next_cycle();
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d left want 0", exp_q.size()); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_lock();
    for (int k = 0; k < 7; k++) begin
      bus.core_req_i    = 1'b1;
      bus.core_we_i     = 1'b1;
      bus.core_funct3_i = FUNCT3_SW;
      bus.core_addr_i   = 32'd400;
      bus.core_wdata_i  = 32'h1111_2222;
      bus.dbg_req_i     = 1'b1;
      bus.dbg_we_i      = 1'b1;
      bus.dbg_be_i      = 4'b0101;
      bus.dbg_addr_i    = 10'd30;
      bus.dbg_wdata_i   = 32'hCAFE_F00D;
      bus.dbg_lock_i    = (k <= 4);
      @(negedge clk);
      if (k == 0 || k == 6) begin
        n_checks++; if (bus.core_gnt_o !== 1'b1) $display("FAIL lock_k%0d_core_gnt: got %b want 1", k, bus.core_gnt_o); else n_pass++;
      end else begin
        n_checks++; if (bus.core_gnt_o !== 1'b0) $display("FAIL lock_k%0d_core_gnt: got %b want 0", k, bus.core_gnt_o); else n_pass++;
        n_checks++; if (bus.dbg_gnt_o !== 1'b1) $display("FAIL lock_k%0d_dbg_gnt: got %b want 1", k, bus.dbg_gnt_o); else n_pass++;
      end
      if (k == 1) begin
        n_checks++; if (dut.state_q !== S_LOCK) $display("FAIL lock_state: got %0d want %0d", dut.state_q, S_LOCK); else n_pass++;
        n_checks++; if ({bus.mem_en_o, bus.mem_we_o, bus.mem_be_o} !== 6'b11_0101) $display("FAIL lock_dbg_ctl: got %b want 110101", {bus.mem_en_o, bus.mem_we_o, bus.mem_be_o}); else n_pass++;
        n_checks++; if (bus.mem_addr_o !== 10'd30 || bus.mem_wdata_o !== 32'hCAFE_F00D) $display("FAIL lock_dbg_pass: got a=%0d d=%h want a=30 d=cafef00d", bus.mem_addr_o, bus.mem_wdata_o); else n_pass++;
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_reset_outstanding();
    bus.core_req_i    = 1'b1;
    bus.core_we_i     = 1'b0;
    bus.core_funct3_i = FUNCT3_LW;
    bus.core_addr_i   = 32'd48;
    bus.dbg_req_i     = 1'b1;
    bus.dbg_addr_i    = 10'd13;
    @(negedge clk);
    n_checks++; if ({bus.core_gnt_o, bus.dbg_gnt_o} !== 2'b10) $display("FAIL rst_rd_gnt: got %b want 10", {bus.core_gnt_o, bus.dbg_gnt_o}); else n_pass++;
    next_cycle();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.core_rvalid_o !== 1'b0) $display("FAIL rst_rd_rvalid_in_reset: got %b want 0", bus.core_rvalid_o); else n_pass++;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.core_rvalid_o !== 1'b0) $display("FAIL rst_rd_rvalid_after: got %b want 0", bus.core_rvalid_o); else n_pass++;
    n_checks++; if (dut.state_q !== S_CORE) $display("FAIL rst_rd_state: got %0d want %0d", dut.state_q, S_CORE); else n_pass++;
    n_checks++; if (dut.starve_cnt_q !== 4'd0) $display("FAIL rst_rd_starve: got %0d want 0", dut.starve_cnt_q); else n_pass++;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_store_lanes();
    test_misalign();
    test_starve();
    test_back_to_back();
    test_lock();
    test_reset_outstanding();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
